// File: rtl/tty_pkg.sv
// Shared types and constants for the teletype transmit scheduler:
// FSM states, stop_sel encodings and the post-frame gap lengths in ticks.
package tty_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [1:0] STOP_1   = 2'd0;
  localparam logic [1:0] STOP_1P5 = 2'd1;
  localparam logic [1:0] STOP_2   = 2'd2;

  // One tick is half a bit time, so 1 / 1.5 / 2 stop bits are 2 / 3 / 4 ticks.
  localparam logic [2:0] GAP_TICKS_1   = 3'd2;
  localparam logic [2:0] GAP_TICKS_1P5 = 3'd3;
  localparam logic [2:0] GAP_TICKS_2   = 3'd4;

  function automatic logic [2:0] gap_ticks(input logic [1:0] stop_sel);
    case (stop_sel)
      STOP_1:   return GAP_TICKS_1;
      STOP_1P5: return GAP_TICKS_1P5;
      STOP_2:   return GAP_TICKS_2;
      default:  return GAP_TICKS_2;
    endcase
  endfunction

endpackage

// File: rtl/tty_baud_tick.sv
// Free-running divisor producing the half-bit shift tick.
// baud_div is only looked at when the counter reloads.
module tty_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tx_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == '0);
    cnt_d  = tick_d ? baud_div : cnt_q - DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tx_tick = tick_q;

endmodule

// File: rtl/tty_tx_sched.sv
// Round-robin arbiter and frame sequencer sharing one teletype transmitter
// between the CPU and host sources. Define TX_STATS_EN for per-source counters.
module tty_tx_sched
  import tty_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int START_TMO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       stop_sel,
  input  logic             req_cpu,
  input  logic [7:0]       data_cpu,
  input  logic             req_host,
  input  logic [7:0]       data_host,
  output logic             gnt_cpu,
  output logic             gnt_host,
  output logic             tx_tick,
  output logic             tx_load,
  output logic [7:0]       tx_data,
  input  logic             tx_active,
  output logic             busy,
  output logic             err_tmo,
  output logic [15:0]      cnt_cpu,
  output logic [15:0]      cnt_host
);

  localparam int TMO_W = (START_TMO > 1) ? $clog2(START_TMO) : 1;

  logic tick;

  tty_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .tx_tick  (tick)
  );

  assign tx_tick = tick;

  state_t     state_q, state_d;
  logic       host_last_q, host_last_d;
  logic       gnt_cpu_q, gnt_cpu_d;
  logic       gnt_host_q, gnt_host_d;
  logic       tx_load_q, tx_load_d;
  logic       err_tmo_q, err_tmo_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [2:0] gap_q, gap_d;
  logic       act_q;

  always_comb begin
    state_d     = state_q;
    host_last_d = host_last_q;
    gnt_cpu_d   = 1'b0;
    gnt_host_d  = 1'b0;
    tx_load_d   = 1'b0;
    err_tmo_d   = 1'b0;
    tx_data_d   = tx_data_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    case (state_q)
      // CPU wins unless the host is also asking and the CPU went last.
      IDLE: begin
        if (req_cpu && (!req_host || host_last_q)) begin
          gnt_cpu_d   = 1'b1;
          tx_data_d   = data_cpu;
          host_last_d = 1'b0;
          state_d     = LOAD;
        end else if (req_host) begin
          gnt_host_d  = 1'b1;
          tx_data_d   = data_host;
          host_last_d = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        tx_load_d = 1'b1;
        tmo_d     = '0;
        state_d   = WAIT_START;
      end
      WAIT_START: begin
        if (tx_active) begin
          state_d = WAIT_DONE;
        end else if (tick) begin
          if (tmo_q == TMO_W'(START_TMO - 1)) begin
            err_tmo_d = 1'b1;
            state_d   = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      WAIT_DONE: begin
        if (act_q && !tx_active) begin
          gap_d   = gap_ticks(stop_sel);
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_q <= 3'd1) begin
            gap_d   = 3'd0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q - 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      host_last_q <= 1'b1;
      gnt_cpu_q   <= 1'b0;
      gnt_host_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      tmo_q       <= '0;
      gap_q       <= 3'd0;
      act_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      host_last_q <= host_last_d;
      gnt_cpu_q   <= gnt_cpu_d;
      gnt_host_q  <= gnt_host_d;
      tx_load_q   <= tx_load_d;
      err_tmo_q   <= err_tmo_d;
      tx_data_q   <= tx_data_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      act_q       <= tx_active;
    end
  end

  assign gnt_cpu  = gnt_cpu_q;
  assign gnt_host = gnt_host_q;
  assign tx_load  = tx_load_q;
  assign tx_data  = tx_data_q;
  assign err_tmo  = err_tmo_q;
  assign busy     = (state_q != IDLE);

`ifdef TX_STATS_EN
  logic [15:0] cnt_cpu_q, cnt_cpu_d;
  logic [15:0] cnt_host_q, cnt_host_d;
  logic        frame_done;

  // A character counts once its frame has finished, i.e. on entry to GAP.
  always_comb begin
    frame_done = (state_q == WAIT_DONE) && (state_d == GAP);
    cnt_cpu_d  = cnt_cpu_q;
    cnt_host_d = cnt_host_q;
    if (frame_done && !host_last_q) cnt_cpu_d = cnt_cpu_q + 16'd1;
    if (frame_done && host_last_q)  cnt_host_d = cnt_host_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_cpu_q  <= 16'd0;
      cnt_host_q <= 16'd0;
    end else begin
      cnt_cpu_q  <= cnt_cpu_d;
      cnt_host_q <= cnt_host_d;
    end
  end

  assign cnt_cpu  = cnt_cpu_q;
  assign cnt_host = cnt_host_q;
`else
  assign cnt_cpu  = 16'd0;
  assign cnt_host = 16'd0;
`endif

endmodule

// File: tb/tb_tty_tx_sched.sv
// Directed self-checking bench for tty_tx_sched; the bench itself plays the
// transmitter by driving tx_active. Honours TX_STATS_EN for counter checks.
module tb_tty_tx_sched;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] baud_div;
  logic [1:0]       stop_sel;
  logic             req_cpu, req_host;
  logic [7:0]       data_cpu, data_host;
  logic             gnt_cpu, gnt_host, tx_tick, tx_load, busy, err_tmo;
  logic [7:0]       tx_data;
  logic             tx_active;
  logic [15:0]      cnt_cpu, cnt_host;

  int checks = 0;
  int failures = 0;
  int exp_cpu = 0;
  int exp_host = 0;

  always #5 clk = ~clk;

  tty_tx_sched #(.DIV_W(DIV_W), .START_TMO(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_div  (baud_div),
    .stop_sel  (stop_sel),
    .req_cpu   (req_cpu),
    .data_cpu  (data_cpu),
    .req_host  (req_host),
    .data_host (data_host),
    .gnt_cpu   (gnt_cpu),
    .gnt_host  (gnt_host),
    .tx_tick   (tx_tick),
    .tx_load   (tx_load),
    .tx_data   (tx_data),
    .tx_active (tx_active),
    .busy      (busy),
    .err_tmo   (err_tmo),
    .cnt_cpu   (cnt_cpu),
    .cnt_host  (cnt_host)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_cpu = 1'b0;
    req_host = 1'b0;
    tx_active = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_cpu = 0;
    exp_host = 0;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (gnt_cpu || gnt_host) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Acts as the transmitter for one character: waits for the load, holds
  // tx_active for act_cycles, then waits for the scheduler to go idle.
  task automatic serve_frame(input bit is_host, input int act_cycles,
                             output bit ok, output bit stray, output logic [7:0] data_seen);
    bit got;
    bit done;
    got = 1'b0;
    done = 1'b0;
    stray = 1'b0;
    data_seen = 8'h00;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_load) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      data_seen = tx_data;
      tx_active = 1'b1;
      for (int i = 0; i < act_cycles; i++) begin
        step();
        if (gnt_cpu || gnt_host) stray = 1'b1;
      end
      tx_active = 1'b0;
      for (int i = 0; i < 500; i++) begin
        step();
        if (gnt_cpu || gnt_host) stray = 1'b1;
        if (!busy) begin
          done = 1'b1;
          break;
        end
      end
      if (done) begin
        if (is_host) exp_host++;
        else exp_cpu++;
      end
    end
    ok = got && done;
  endtask

  task automatic test_reset();
    logic [15:0] want;
    rst = 1'b1;
    baud_div = 16'd3;
    stop_sel = 2'd0;
    req_cpu = 1'b1;
    req_host = 1'b1;
    data_cpu = 8'hAA;
    data_host = 8'h55;
    tx_active = 1'b0;
    step();
    step();
    step();
    checks++;
    if ({gnt_cpu, gnt_host, tx_tick, tx_load, busy, err_tmo, tx_data} !== 14'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b want 0",
               {gnt_cpu, gnt_host, tx_tick, tx_load, busy, err_tmo, tx_data});
    end
    want = 16'd0;
    checks++;
    if ({cnt_cpu, cnt_host} !== {want, want}) begin
      failures++;
      $display("[TB] FAIL reset_counters: got %h/%h want 0/0", cnt_cpu, cnt_host);
    end
    req_cpu = 1'b0;
    req_host = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_tick_timing();
    int got_iv[4];
    int want_iv[4];
    int n;
    bit found;
    want_iv = '{4, 4, 2, 2};
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_tick) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL tick_first: got no tick want tick within 20 cycles");
    end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        n++;
        if (tx_tick) break;
      end
      got_iv[k] = n;
      if (k == 0) baud_div = 16'd1;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_iv[k] !== want_iv[k]) begin
        failures++;
        $display("[TB] FAIL tick_interval_%0d: got %0d want %0d", k, got_iv[k], want_iv[k]);
      end
    end
    baud_div = 16'd3;
    repeat (6) step();
  endtask

  task automatic test_single_cpu();
    int n;
    int ticks;
    logic [15:0] want;
    stop_sel = 2'd0;
    data_cpu = 8'h41;
    req_cpu = 1'b1;
    step();
    checks++;
    if ({gnt_cpu, gnt_host, tx_load} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL single_grant: got gnt_cpu,gnt_host,load=%b want 100", {gnt_cpu, gnt_host, tx_load});
    end
    req_cpu = 1'b0;
    step();
    checks++;
    if ({gnt_cpu, tx_load, busy, tx_data} !== {3'b011, 8'h41}) begin
      failures++;
      $display("[TB] FAIL single_load: got gnt,load,busy=%b data=%h want 011 data=41",
               {gnt_cpu, tx_load, busy}, tx_data);
    end
    tx_active = 1'b1;
    n = 0;
    for (int i = 0; i < 400 && n < 22; i++) begin
      step();
      if (tx_tick) n++;
    end
    tx_active = 1'b0;
    step();
    ticks = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      if (tx_tick) ticks++;
      step();
    end
    checks++;
    if (busy !== 1'b0 || ticks != 2) begin
      failures++;
      $display("[TB] FAIL single_gap: got busy=%b gap_ticks=%0d want busy=0 gap_ticks=2", busy, ticks);
    end
    exp_cpu++;
    checks++;
    if (tx_data !== 8'h41) begin
      failures++;
      $display("[TB] FAIL single_data_hold: got %h want 41", tx_data);
    end
`ifdef TX_STATS_EN
    want = 16'(exp_cpu);
`else
    want = 16'd0;
`endif
    checks++;
    if (cnt_cpu !== want) begin
      failures++;
      $display("[TB] FAIL single_cnt_cpu: got %0d want %0d", cnt_cpu, want);
    end
  endtask

  task automatic test_contention();
    bit ok;
    bit stray;
    bit want_host;
    logic [7:0] seen;
    logic [31:0] want;
    do_reset();
    baud_div = 16'd0;
    stop_sel = 2'd0;
    data_cpu = 8'h43;
    data_host = 8'h48;
    repeat (3) step();
    req_cpu = 1'b1;
    req_host = 1'b1;
    for (int i = 0; i < 4; i++) begin
      want_host = (i % 2) == 1;
      wait_gnt(ok);
      checks++;
      if (!ok || {gnt_cpu, gnt_host} !== {!want_host, want_host}) begin
        failures++;
        $display("[TB] FAIL contention_order_%0d: got gnt_cpu,gnt_host=%b want %b",
                 i, {gnt_cpu, gnt_host}, {!want_host, want_host});
        break;
      end
      if (i == 2) req_cpu = 1'b0;
      if (i == 3) req_host = 1'b0;
      serve_frame(want_host, 6, ok, stray, seen);
      checks++;
      if (!ok || stray || seen !== (want_host ? 8'h48 : 8'h43)) begin
        failures++;
        $display("[TB] FAIL contention_frame_%0d: got ok=%b early_gnt=%b data=%h want ok=1 early_gnt=0 data=%h",
                 i, ok, stray, seen, want_host ? 8'h48 : 8'h43);
      end
    end
    req_cpu = 1'b0;
    req_host = 1'b0;
`ifdef TX_STATS_EN
    want = {16'd2, 16'd2};
`else
    want = 32'd0;
`endif
    checks++;
    if ({cnt_cpu, cnt_host} !== want) begin
      failures++;
      $display("[TB] FAIL contention_counts: got %0d/%0d want %0d/%0d",
               cnt_cpu, cnt_host, want[31:16], want[15:0]);
    end
  endtask

  task automatic test_stop_gap();
    bit ok;
    bit stray;
    logic [7:0] seen;
    int ticks;
    logic [1:0] sels[3];
    int wants[3];
    sels = '{2'd1, 2'd2, 2'd3};
    wants = '{3, 4, 4};
    baud_div = 16'd2;
    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      data_cpu = 8'h30 + 8'(k);
      req_cpu = 1'b1;
      wait_gnt(ok);
      req_cpu = 1'b0;
      for (int i = 0; i < 5 && !tx_load; i++) step();
      tx_active = 1'b1;
      repeat (4) step();
      req_cpu = 1'b1;
      stop_sel = sels[k];
      tx_active = 1'b0;
      step();
      stop_sel = 2'd0;
      ticks = 0;
      for (int i = 0; i < 200 && !gnt_cpu; i++) begin
        if (busy && tx_tick) ticks++;
        step();
      end
      exp_cpu++;
      checks++;
      if (!gnt_cpu || ticks != wants[k]) begin
        failures++;
        $display("[TB] FAIL stop_gap_sel%0d: got gnt=%b gap_ticks=%0d want gnt=1 gap_ticks=%0d",
                 sels[k], gnt_cpu, ticks, wants[k]);
      end
      req_cpu = 1'b0;
      serve_frame(1'b0, 3, ok, stray, seen);
      checks++;
      if (!ok || seen !== 8'h30 + 8'(k)) begin
        failures++;
        $display("[TB] FAIL stop_gap_next_%0d: got ok=%b data=%h want ok=1 data=%h", k, ok, seen, 8'h30 + 8'(k));
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] want;
    baud_div = 16'd0;
    stop_sel = 2'd0;
    repeat (5) step();
    data_cpu = 8'h7E;
    req_cpu = 1'b1;
    step();
    req_cpu = 1'b0;
    step();
    checks++;
    if (tx_load !== 1'b1) begin
      failures++;
      $display("[TB] FAIL tmo_load: got %b want 1", tx_load);
    end
    tx_active = 1'b0;
    repeat (3) step();
    checks++;
    if ({err_tmo, busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL tmo_early: got err,busy=%b want 01", {err_tmo, busy});
    end
    step();
    checks++;
    if ({err_tmo, busy} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL tmo_fire: got err,busy=%b want 10", {err_tmo, busy});
    end
    step();
    checks++;
    if (err_tmo !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tmo_pulse: got %b want 0", err_tmo);
    end
`ifdef TX_STATS_EN
    want = 16'(exp_cpu);
`else
    want = 16'd0;
`endif
    checks++;
    if (cnt_cpu !== want) begin
      failures++;
      $display("[TB] FAIL tmo_cnt_cpu: got %0d want %0d", cnt_cpu, want);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit stray;
    logic [7:0] seen;
    logic [31:0] want;
    data_cpu = 8'h5A;
    req_cpu = 1'b1;
    step();
    req_cpu = 1'b0;
    step();
    tx_active = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++;
    if ({gnt_cpu, gnt_host, tx_tick, tx_load, busy, err_tmo, tx_data, cnt_cpu, cnt_host} !== 46'h0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got busy=%b load=%b gnt=%b%b data=%h cnt=%0d/%0d want all 0",
               busy, tx_load, gnt_cpu, gnt_host, tx_data, cnt_cpu, cnt_host);
    end
    rst = 1'b0;
    tx_active = 1'b0;
    exp_cpu = 0;
    exp_host = 0;
    step();
    data_cpu = 8'h61;
    data_host = 8'h62;
    req_cpu = 1'b1;
    req_host = 1'b1;
    step();
    checks++;
    if ({gnt_cpu, gnt_host} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL midreset_pointer: got gnt_cpu,gnt_host=%b want 10", {gnt_cpu, gnt_host});
    end
    req_cpu = 1'b0;
    serve_frame(1'b0, 4, ok, stray, seen);
    checks++;
    if (!ok || seen !== 8'h61) begin
      failures++;
      $display("[TB] FAIL midreset_cpu_frame: got ok=%b data=%h want ok=1 data=61", ok, seen);
    end
    wait_gnt(ok);
    checks++;
    if (!ok || gnt_host !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_host_grant: got ok=%b gnt_host=%b want 1/1", ok, gnt_host);
    end
    req_host = 1'b0;
    serve_frame(1'b1, 4, ok, stray, seen);
    checks++;
    if (!ok || seen !== 8'h62) begin
      failures++;
      $display("[TB] FAIL midreset_host_frame: got ok=%b data=%h want ok=1 data=62", ok, seen);
    end
`ifdef TX_STATS_EN
    want = {16'd1, 16'd1};
`else
    want = 32'd0;
`endif
    checks++;
    if ({cnt_cpu, cnt_host} !== want) begin
      failures++;
      $display("[TB] FAIL midreset_counts: got %0d/%0d want %0d/%0d",
               cnt_cpu, cnt_host, want[31:16], want[15:0]);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_tick_timing();
    test_single_cpu();
    test_contention();
    test_stop_gap();
    test_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
